// File: rtl/fcmp_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcmp_arb_if                                                           |
// | Request/response bundle between FPU issue logic and fcmp_arb.        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fcmp_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_opa;
  logic [32*NREQ-1:0]   req_opb;
  logic [3*NREQ-1:0]    req_pred;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_result;
  logic [3:0]           rsp_flags;

  modport master (
    output req_valid, req_opa, req_opb, req_pred, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_opa, req_opb, req_pred, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
  );
endinterface
`default_nettype wire

// File: rtl/fcmp_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fcmp_arb                                                              |
// | Round-robin arbiter sharing one single-precision fcmp among NREQ     |
// | requesters. Optional macro FCMP_ARB_CNT_EN adds cmp_count.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+

module fcmp (
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        unordered,
  output logic        altb,
  output logic        blta,
  output logic        aeqb,
  output logic        inf,
  output logic        zero
);
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_both_zero, w_mag_lt, w_mag_gt;

  assign w_a_nan     = (opa[30:23] == 8'hFF) && (opa[22:0] != 23'd0);
  assign w_b_nan     = (opb[30:23] == 8'hFF) && (opb[22:0] != 23'd0);
  assign w_a_inf     = (opa[30:23] == 8'hFF) && (opa[22:0] == 23'd0);
  assign w_b_inf     = (opb[30:23] == 8'hFF) && (opb[22:0] == 23'd0);
  assign w_both_zero = (opa[30:0] == 31'd0) && (opb[30:0] == 31'd0);
  assign w_mag_lt    = opa[30:0] < opb[30:0];
  assign w_mag_gt    = opa[30:0] > opb[30:0];

  assign unordered = w_a_nan | w_b_nan;
  assign inf       = w_a_inf | w_b_inf;
  assign zero      = w_both_zero;
  assign aeqb      = !unordered && ((opa == opb) || w_both_zero);

  // Sign-magnitude ordering; +0 and -0 compare equal, so both-zero never orders.
  assign altb = !unordered && !w_both_zero &&
                (( opa[31] && !opb[31]) ||
                 (!opa[31] && !opb[31] && w_mag_lt) ||
                 ( opa[31] &&  opb[31] && w_mag_gt));
  assign blta = !unordered && !w_both_zero &&
                ((!opa[31] &&  opb[31]) ||
                 (!opa[31] && !opb[31] && w_mag_gt) ||
                 ( opa[31] &&  opb[31] && w_mag_lt));
endmodule

module fcmp_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst,
  fcmp_arb_if.slave   bus
`ifdef FCMP_ARB_CNT_EN
  ,
  output logic [31:0] cmp_count
`endif
);
  localparam logic [2:0] c_PRED_EQ  = 3'd0;
  localparam logic [2:0] c_PRED_LT  = 3'd1;
  localparam logic [2:0] c_PRED_LE  = 3'd2;
  localparam logic [2:0] c_PRED_GT  = 3'd3;
  localparam logic [2:0] c_PRED_GE  = 3'd4;
  localparam logic [2:0] c_PRED_UN  = 3'd5;
  localparam logic [2:0] c_PRED_NE  = 3'd6;
  localparam logic [2:0] c_PRED_ILL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IDW-1:0]  r_last, r_id, w_win, w_idx;
  logic            w_found, w_grant, w_cap_rsp;
  logic [NREQ-1:0] w_ready;
  logic [31:0]     r_opa, r_opb;
  logic [2:0]      r_pred;
  logic            r_rsp_valid, r_rsp_result;
  logic [IDW-1:0]  r_rsp_id;
  logic [3:0]      r_rsp_flags;
  logic            w_unordered, w_altb, w_blta, w_aeqb, w_inf, w_zero, w_result;
  logic [31:0]     w_opa_arr  [NREQ];
  logic [31:0]     w_opb_arr  [NREQ];
  logic [2:0]      w_pred_arr [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_opa_arr[k]  = bus.req_opa[32*k +: 32];
    assign w_opb_arr[k]  = bus.req_opb[32*k +: 32];
    assign w_pred_arr[k] = bus.req_pred[3*k +: 3];
  end

  // Scan from farthest to nearest offset so the nearest requester after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = IDW'((int'(r_last) + i) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_cap_rsp   = 1'b0;
    w_ready     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !rst) begin
          w_grant        = 1'b1;
          w_ready[w_win] = 1'b1;
          w_state_nxt    = S_CMP;
        end
      end
      S_CMP: begin
        w_cap_rsp   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa  <= '0;
      r_opb  <= '0;
      r_pred <= '0;
      r_id   <= '0;
      r_last <= IDW'(NREQ - 1);
    end else if (w_grant) begin
      r_opa  <= w_opa_arr[w_win];
      r_opb  <= w_opb_arr[w_win];
      r_pred <= w_pred_arr[w_win];
      r_id   <= w_win;
      r_last <= w_win;
    end
  end

  fcmp u_fcmp (
    .opa       (r_opa),
    .opb       (r_opb),
    .unordered (w_unordered),
    .altb      (w_altb),
    .blta      (w_blta),
    .aeqb      (w_aeqb),
    .inf       (w_inf),
    .zero      (w_zero)
  );

  // NaN already clears altb/blta/aeqb, which yields 0 for the ordered predicates.
  always_comb begin
    w_result = 1'b0;
    case (r_pred)
      c_PRED_EQ:  w_result = w_aeqb;
      c_PRED_LT:  w_result = w_altb;
      c_PRED_LE:  w_result = w_altb | w_aeqb;
      c_PRED_GT:  w_result = w_blta;
      c_PRED_GE:  w_result = w_blta | w_aeqb;
      c_PRED_UN:  w_result = w_unordered;
      c_PRED_NE:  w_result = !w_aeqb;
      default:    w_result = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= 1'b0;
      r_rsp_flags  <= '0;
    end else begin
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_cap_rsp) begin
        r_rsp_id     <= r_id;
        r_rsp_result <= w_result;
        r_rsp_flags  <= {(r_pred == c_PRED_ILL), w_unordered, w_inf, w_zero};
      end
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_flags  = r_rsp_flags;

`ifdef FCMP_ARB_CNT_EN
  logic [31:0] r_cmp_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_cmp_count <= '0;
    else if (r_rsp_valid && bus.rsp_ready) r_cmp_count <= r_cmp_count + 32'd1;
  end

  assign cmp_count = r_cmp_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fcmp_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fcmp_arb                                                           |
// | Randomized scoreboard bench for fcmp_arb with directed corner cases. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fcmp_arb;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcmp_arb_if #(.NREQ(NREQ)) bus ();
`ifdef FCMP_ARB_CNT_EN
  wire [31:0] cmp_count;
`endif

  fcmp_arb #(.NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FCMP_ARB_CNT_EN
    ,
    .cmp_count (cmp_count)
`endif
  );

  typedef struct { int id; logic res; logic [3:0] flags; int gcyc; } exp_t;
  typedef struct { int id; int cyc; } glog_t;

  exp_t  exq[$];
  glog_t glog[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    gcount [NREQ];
  int    seen_g [NREQ];
  bit    outstanding = 0;
  bit    front_seen = 0;
  bit    refill = 0;
  int    m_last = NREQ - 1;
  int    m_cnt = 0;
  int    win;
  bit    idle;
  logic [NREQ-1:0] exp_rdy;
  logic [4:0]      r;
  logic [31:0] pool [10] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'h40000000,
                             32'hBF800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7F800001, 32'hC0000000};

  // Reference: map each non-NaN float to a monotone signed integer key.
  function automatic logic [4:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] p);
    bit     na, nb, un, finf, fzero, lt, gt, eq, res;
    longint ka, kb;
    na    = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb    = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    un    = na || nb;
    finf  = (a[30:0] == 31'h7F800000) || (b[30:0] == 31'h7F800000);
    fzero = (a[30:0] == 0) && (b[30:0] == 0);
    ka    = a[31] ? -longint'({33'd0, a[30:0]}) : longint'({33'd0, a[30:0]});
    kb    = b[31] ? -longint'({33'd0, b[30:0]}) : longint'({33'd0, b[30:0]});
    lt    = !un && (ka < kb);
    gt    = !un && (ka > kb);
    eq    = !un && (ka == kb);
    case (p)
      3'd0: res = eq;
      3'd1: res = lt;
      3'd2: res = lt || eq;
      3'd3: res = gt;
      3'd4: res = gt || eq;
      3'd5: res = un;
      3'd6: res = !eq;
      default: res = 1'b0;
    endcase
    return {res, (p == 3'd7), un, finf, fzero};
  endfunction

  function automatic logic [31:0] rand_op();
    int sel;
    sel = $urandom_range(0, 13);
    if (sel < 10) return pool[sel];
    return $urandom;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic post(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] p);
    bus.req_opa[32*k +: 32] = a;
    bus.req_opb[32*k +: 32] = b;
    bus.req_pred[3*k +: 3]  = p;
    bus.req_valid[k]        = 1'b1;
  endtask

  task automatic post_rand(input int k);
    logic [31:0] a, b;
    a = rand_op();
    b = ($urandom_range(0, 4) == 0) ? a : rand_op();
    post(k, a, b, 3'($urandom_range(0, 7)));
  endtask

  // Advance one cycle; retire (or refill) every request the monitor saw granted.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (gcount[k] != seen_g[k]) begin
        seen_g[k] = gcount[k];
        if (refill) post_rand(k);
        else        bus.req_valid[k] = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int n;
    n = 0;
    while ((bus.req_valid != '0 || outstanding) && n < maxc) begin
      step();
      n++;
    end
    chk(bus.req_valid == '0 && !outstanding, name, {bus.req_valid, outstanding}, 0);
  endtask

  logic [31:0] da [6] = '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                          32'h80000000, 32'h7F800000, 32'h3F800000};
  logic [31:0] db [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000,
                          32'h00000000, 32'h3F800000, 32'h3F800000};
  logic [2:0]  dp [6] = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd3, 3'd7};

  initial begin
    bus.req_valid = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.req_pred  = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      gcount[k] = 0;
      seen_g[k] = 0;
    end

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
          chk(bus.req_ready == '0, "rst_req_ready", bus.req_ready, 0);
          chk({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags} == '0, "rst_rsp",
              {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 0);
          exq.delete();
          glog.delete();
          outstanding = 0;
          front_seen  = 0;
          m_last      = NREQ - 1;
          m_cnt       = 0;
        end else begin
          idle = !outstanding;
`ifdef FCMP_ARB_CNT_EN
          chk(cmp_count == 32'(m_cnt), "cmp_count", cmp_count, m_cnt);
`endif
          if (bus.rsp_valid) begin
            if (exq.size() == 0) begin
              chk(1'b0, "rsp_unexpected", bus.rsp_id, 0);
            end else begin
              chk({bus.rsp_id, bus.rsp_result, bus.rsp_flags} ==
                  {IDW'(exq[0].id), exq[0].res, exq[0].flags}, "rsp_data",
                  {bus.rsp_id, bus.rsp_result, bus.rsp_flags},
                  {IDW'(exq[0].id), exq[0].res, exq[0].flags});
              if (!front_seen) begin
                chk(cyc == exq[0].gcyc + 2, "rsp_latency", cyc - exq[0].gcyc, 2);
                front_seen = 1;
              end
              if (bus.rsp_ready) begin
                void'(exq.pop_front());
                front_seen  = 0;
                outstanding = 0;
                m_cnt++;
              end
            end
          end
          exp_rdy = '0;
          win     = -1;
          if (idle) begin
            for (int i = 1; i <= NREQ; i++) begin
              if (win < 0 && bus.req_valid[(m_last + i) % NREQ]) win = (m_last + i) % NREQ;
            end
          end
          if (win >= 0) exp_rdy[win] = 1'b1;
          chk(bus.req_ready == exp_rdy, "grant", bus.req_ready, exp_rdy);
          if (win >= 0) begin
            exp_t  e;
            glog_t g;
            r = ref_cmp(bus.req_opa[32*win +: 32], bus.req_opb[32*win +: 32],
                        bus.req_pred[3*win +: 3]);
            e.id = win; e.res = r[4]; e.flags = r[3:0]; e.gcyc = cyc;
            exq.push_back(e);
            g.id = win; g.cyc = cyc;
            glog.push_back(g);
            m_last      = win;
            outstanding = 1;
            gcount[win]++;
          end
        end
      end
    join_none

    repeat (3) step();
    rst = 1'b0;

    // Single request: 1.0 < 2.0 from requester 0.
    post(0, 32'h3F800000, 32'h40000000, 3'd1);
    wait_drain(20, "single_drain");

    // NaN, signed zero, infinity and illegal predicate on random requesters.
    for (int t = 0; t < 6; t++) begin
      post($urandom_range(0, NREQ - 1), da[t], db[t], dp[t]);
      wait_drain(20, "directed_drain");
    end

    // Fairness: every requester valid continuously out of reset.
    rst = 1'b1;
    step();
    refill = 1;
    for (int k = 0; k < NREQ; k++) post_rand(k);
    step();
    rst = 1'b0;
    for (int n = 0; n < 40 && glog.size() < 5; n++) step();
    chk(glog.size() >= 5, "fair_count", glog.size(), 5);
    if (glog.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk(glog[i].id == i % NREQ, "fair_order", glog[i].id, i % NREQ);
      for (int i = 1; i < 5; i++)
        chk(glog[i].cyc - glog[i-1].cyc == 3, "fair_spacing", glog[i].cyc - glog[i-1].cyc, 3);
    end
    refill = 0;
    wait_drain(60, "fair_drain");

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NREQ; k++)
        if (!bus.req_valid[k] && $urandom_range(0, 4) == 0) post_rand(k);
      step();
    end
    bus.rsp_ready = 1'b1;
    wait_drain(100, "random_drain");

    // Stall in RESP, then reset while the response is pending.
    bus.rsp_ready = 1'b0;
    post(2, rand_op(), rand_op(), 3'($urandom_range(0, 7)));
    for (int n = 0; n < 10 && !bus.rsp_valid; n++) step();
    chk(bus.rsp_valid == 1'b1, "bp_reach_resp", bus.rsp_valid, 1);
    post_rand(1);
    post_rand(3);
    post_rand(0);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk(bus.rsp_valid == 1'b0 && bus.req_ready == '0, "rst_async",
        {bus.rsp_valid, bus.req_ready}, 0);
    step();
    step();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 10 && glog.size() == 0; n++) step();
    chk(glog.size() > 0 && glog[0].id == 0, "rst_first_grant",
        (glog.size() > 0) ? glog[0].id : -1, 0);
    wait_drain(60, "final_drain");
    chk(exq.size() == 0, "leftover", exq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fcmp_arb.md
# fcmp_arb

Round-robin arbiter and sequencer that shares one single-precision `fcmp` compare unit among `NREQ` requesters. Each requester issues an operand pair plus a compare predicate over a valid/ready handshake. The block registers the winning request, evaluates it through an internal `fcmp` instance, and returns a one-bit predicate result, IEEE status flags and the requester ID on a single registered response channel. It sits between the FPU issue logic and the shared `fcmp` datapath.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID; derived, do not override.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit k high means requester k presents a request.
- `req_ready`  out  NREQ  one-hot grant; bit k high means request k is accepted this cycle.
- `req_opa`  in  32*NREQ  operand A; slice k is `[32k+31:32k]`.
- `req_opb`  in  32*NREQ  operand B; same slicing as `req_opa`.
- `req_pred`  in  3*NREQ  predicate code; slice k is `[3k+2:3k]`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  IDW  index of the requester that owns the response.
- `rsp_result`  out  1  predicate outcome.
- `rsp_flags`  out  4  `{illegal, unordered, inf, zero}`, taken from `fcmp` for the captured operands.

## Operation
- The block instantiates one `fcmp`. Its inputs are driven only from the internal operand registers `opa_r` and `opb_r`.
- Predicate codes and their results:
  - 000 EQ: `aeqb`.
  - 001 LT: `altb`.
  - 010 LE: `altb|aeqb`.
  - 011 GT: `blta`.
  - 100 GE: `blta|aeqb`.
  - 101 UN: `unordered`.
  - 110 NE: `~aeqb`, which is 1 when either operand is NaN.
  - 111 is illegal: `rsp_result`=0 and `flags[3]`=1.
- For every predicate except NE, a NaN operand forces `rsp_result`=0.
- State machine, with all transitions on the rising edge of `clk`:
  - IDLE: if any `req_valid` bit is high, grant the winner. `req_ready[w]`=1 combinationally in this cycle only. Capture `opa`, `opb`, `pred` and `w`, then go to CMP. With no request, stay in IDLE.
  - CMP: `fcmp` evaluates `opa_r`/`opb_r`. Register the result, flags and ID into the response registers and go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`=1, go to IDLE. Otherwise hold, keeping every `rsp_*` output stable.
- `req_ready` is all-zero outside IDLE.
- Round-robin: pointer `last` holds the most recent grant. Search starts at `last+1` modulo NREQ and `last` updates on each grant. Its reset value is NREQ-1, so requester 0 wins first.
- Requesters must hold `req_valid` and data stable until granted. Dropping `req_valid` before a grant is allowed and simply removes that request.
- Reset values (asynchronous): state IDLE, `last`=NREQ-1, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0, operand registers 0.
- Reset mid-operation: any in-flight request is discarded without a response. `req_ready` is 0 while `rst` is high.

## Timing
- A request granted in cycle N gives `rsp_valid`=1 from cycle N+2, counted in rising edges after the grant edge.
- Minimum spacing between grants is 3 cycles. Each cycle of `rsp_ready`=0 in RESP adds one cycle.
- When `rsp_ready`=1 in the first RESP cycle, the next grant can occur in cycle N+3.
- `rsp_*` outputs come straight from registers. `req_ready` is combinational from `req_valid`, the state and `last`.
- A request arriving while RESP is stalled waits. It is arbitrated in the first IDLE cycle.

## Configuration
- `FCMP_ARB_CNT_EN` defined:
  - Adds output port `cmp_count` (32 bits, resets to 0).
  - It increments on every cycle with `rsp_valid & rsp_ready`.
  - It wraps from 32'hFFFFFFFF to 0.
- Not defined: the port and counter are absent and all other behaviour is identical.

## Test plan
- Single request: requester 0 sends `opa`=3F800000 (1.0), `opb`=40000000 (2.0), pred LT; `rsp_ready`=1 → `rsp_valid` 2 cycles after the grant, `rsp_id`=0, `rsp_result`=1, `rsp_flags`=0.
- Fairness: all 4 requesters hold valid continuously from reset → grant order 0,1,2,3,0, one grant every 3 cycles.
- NaN handling: `opa`=7FC00000, `opb`=3F800000; pred EQ → result 0, `flags[2]`=1; pred NE → result 1; pred UN → result 1.
- Zero, infinity and illegal code:
  - `opa`=80000000, `opb`=00000000, pred EQ → result 1, `flags[0]`=1.
  - `opa`=7F800000, `opb`=3F800000, pred GT → result 1, `flags[1]`=1.
  - pred 111 → result 0, `flags[3]`=1.
- Backpressure and reset: hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable and `req_ready`=0 throughout. Then assert `rst` mid-RESP → `rsp_valid`=0 immediately, no response for that request, and requester 0 is granted first after `rst` deasserts.
